// File: rtl/multi_timer.sv
// multi_timer: multi-channel programmable down-counter timer.
//   One shared prescaler, qualified by clken, produces a tick every
//   prescale+1 qualified cycles. Each channel is an independent down-counter
//   with its own reload value, periodic/one-shot mode, run state, sticky irq,
//   zero pulse and toggle output.
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   clken, prescale     count qualifier and shared prescaler divide value
//   cfg_we/ch/load/mode/start   config write of one channel; start arms it
//   stop, irq_ack       per-channel stop level and irq clear
//   counter_flat        channel i count at [i*WIDTH +: WIDTH]
//   zero, tp, irq, running      per-channel status outputs

module multi_timer_ch #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr,
  input  logic             arm,
  input  logic [WIDTH-1:0] load,
  input  logic             mode_in,
  input  logic             stop,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tp,
  output logic             irq,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, count_n, arm_val, rel_val;
  logic             mode, term;

  // A load of 0 behaves as 1, so the counter restarts at max(N,1)-1.
  assign arm_val = ((load   == '0) ? WIDTH'(1) : load)   - WIDTH'(1);
  assign rel_val = ((reload == '0) ? WIDTH'(1) : reload) - WIDTH'(1);

  // Arm wins over stop, stop wins over counting; an arm on a terminal
  // cycle therefore also swallows that terminal event.
  always_comb begin
    state_n = state;
    count_n = count;
    term    = 1'b0;
    if (arm) begin
      state_n = RUN;
      count_n = arm_val;
    end else if (state == RUN) begin
      if (stop) begin
        state_n = IDLE;
      end else if (tick) begin
        if (count != '0) begin
          count_n = count - WIDTH'(1);
        end else begin
          term = 1'b1;
          if (mode) state_n = DONE;
          else      count_n = rel_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      zero   <= 1'b0;
      tp     <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      zero  <= term;
      tp    <= tp ^ term;
      irq   <= (irq & ~irq_ack) | term;  // set beats ack
      // Reload/mode updates take effect from the next terminal reload on.
      if (wr) begin
        reload <= load;
        mode   <= mode_in;
      end
    end
  end

  assign running = (state == RUN);
endmodule

module multi_timer #(
  parameter int WIDTH      = 24,
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 8,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [WIDTH-1:0]          cfg_load,
  input  logic                      cfg_mode,
  input  logic                      cfg_start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       irq_ack,
  output logic [CHANNELS*WIDTH-1:0] counter_flat,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       tp,
  output logic [CHANNELS-1:0]       irq,
  output logic [CHANNELS-1:0]       running
);
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  tick;

  // >= rather than == so lowering prescale mid-count takes effect at once.
  assign tick = clken && (pre_cnt >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      pre_cnt <= '0;
    else if (tick)  pre_cnt <= '0;
    else if (clken) pre_cnt <= pre_cnt + PRESCALE_W'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range cfg_ch values never match any channel and are ignored.
    logic sel;
    assign sel = cfg_we && (cfg_ch == CH_W'(i));

    multi_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .wr      (sel),
      .arm     (sel && cfg_start),
      .load    (cfg_load),
      .mode_in (cfg_mode),
      .stop    (stop[i]),
      .irq_ack (irq_ack[i]),
      .count   (counter_flat[i*WIDTH +: WIDTH]),
      .zero    (zero[i]),
      .tp      (tp[i]),
      .irq     (irq[i]),
      .running (running[i])
    );
  end
endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the timer rules.
module tb_multi_timer;
  localparam int W = 24, CH = 3, PW = 8, CHW = 2;

  logic              clk = 1'b0;
  logic              reset, clken, cfg_we, cfg_mode, cfg_start;
  logic [PW-1:0]     prescale;
  logic [CHW-1:0]    cfg_ch;
  logic [W-1:0]      cfg_load;
  logic [CH-1:0]     stop, irq_ack;
  logic [CH*W-1:0]   counter_flat;
  logic [CH-1:0]     zero, tp, irq, running;

  multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .clken(clken), .prescale(prescale),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_start(cfg_start), .stop(stop), .irq_ack(irq_ack),
    .counter_flat(counter_flat), .zero(zero), .tp(tp), .irq(irq), .running(running)
  );

  always #5 clk = ~clk;

  // Model: state 0=idle, 1=run, 2=done; counts held as plain integers.
  int m_pre;
  int m_cnt[CH], m_rel[CH], m_st[CH];
  bit m_mode[CH], m_tp[CH], m_irq[CH], m_zero[CH];
  int errors = 0, checks = 0;
  int zc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pre = 0;
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_st[c] = 0;
      m_mode[c] = 0; m_tp[c] = 0; m_irq[c] = 0; m_zero[c] = 0;
    end
  endfunction

  function automatic int eff(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_edge();
    bit tk, hit, term;
    tk = clken && (m_pre >= int'(prescale));
    if (tk) m_pre = 0; else if (clken) m_pre = m_pre + 1;
    for (int c = 0; c < CH; c++) begin
      hit  = cfg_we && (int'(cfg_ch) == c);
      term = 0;
      if (hit && cfg_start) begin
        m_st[c]  = 1;
        m_cnt[c] = eff(int'(cfg_load)) - 1;
      end else if (m_st[c] == 1) begin
        if (stop[c]) m_st[c] = 0;
        else if (tk) begin
          if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
          else begin
            term = 1;
            if (m_mode[c]) m_st[c] = 2;
            else m_cnt[c] = eff(m_rel[c]) - 1;
          end
        end
      end
      m_zero[c] = term;
      if (term) m_tp[c] = !m_tp[c];
      m_irq[c] = (m_irq[c] && !irq_ack[c]) || term;
      if (hit) begin
        m_rel[c]  = int'(cfg_load);
        m_mode[c] = cfg_mode;
      end
    end
  endfunction

  task automatic compare_all();
    logic [CH*W-1:0] ec;
    logic [CH-1:0]   ez, et, ei, er;
    for (int c = 0; c < CH; c++) begin
      ec[c*W +: W] = W'(m_cnt[c]);
      ez[c] = m_zero[c]; et[c] = m_tp[c]; ei[c] = m_irq[c]; er[c] = (m_st[c] == 1);
    end
    chk("counter", counter_flat, ec);
    chk("zero", zero, ez);
    chk("tp", tp, et);
    chk("irq", irq, ei);
    chk("running", running, er);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic arm(input int c, input int n, input bit md);
    cfg_we = 1; cfg_start = 1; cfg_ch = CHW'(c); cfg_load = W'(n); cfg_mode = md;
    step();
    cfg_we = 0; cfg_start = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  // Step until the model's channel c is about to hit its terminal count.
  task automatic wait_term(input int c, input string tag);
    int n;
    n = 0;
    while (!(m_st[c] == 1 && m_cnt[c] == 0) && n < 20) begin
      step();
      n++;
    end
    chk(tag, (n < 20), 1'b1);
  endtask

  initial begin
    reset = 1; clken = 0; prescale = '0; cfg_we = 0; cfg_ch = '0; cfg_load = '0;
    cfg_mode = 0; cfg_start = 0; stop = '0; irq_ack = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_counter", counter_flat, '0);
    chk("rst_running", running, '0);
    reset = 0;

    // Periodic N=3 at full tick rate: counter 2,1,0,2 and zero every 3rd cycle.
    clken = 1; prescale = 0;
    arm(0, 3, 0);
    chk("t2_arm_cnt", counter_flat[W-1:0], 2);
    zc = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (zero[0]) zc++;
    end
    chk("t2_zero_count", zc, 3);
    chk("t2_tp", tp[0], 1'b1);

    // Reset mid-count clears everything immediately, without a clock edge.
    #2 reset = 1;
    #1;
    chk("t1_counter", counter_flat, '0);
    chk("t1_zero", zero, '0);
    chk("t1_tp", tp, '0);
    chk("t1_irq", irq, '0);
    chk("t1_running", running, '0);
    model_reset();
    @(negedge clk);
    reset = 0;

    // One-shot N=5 with prescale 3: exactly one terminal, then DONE with irq held.
    prescale = 3;
    arm(1, 5, 1);
    zc = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (zero[1]) zc++;
    end
    chk("t3_zero_once", zc, 1);
    chk("t3_running", running[1], 1'b0);
    chk("t3_counter", counter_flat[W +: W], 0);
    chk("t3_irq", irq[1], 1'b1);
    repeat (3) step();
    irq_ack[1] = 1; step(); irq_ack[1] = 0;
    chk("t3_irq_ack", irq[1], 1'b0);

    // clken toggling, prescale 1, N=2: terminal every 8 clocks.
    do_reset();
    prescale = 1;
    arm(0, 2, 0);
    zc = 0;
    for (int k = 0; k < 32; k++) begin
      clken = ~clken;
      step();
      if (zero[0]) zc++;
    end
    chk("t4_zero_count", zc, 4);
    clken = 0;
    zc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (zero[0]) zc++;
    end
    chk("t4_frozen", zc, 0);

    // Arm on the terminal cycle suppresses the terminal event.
    clken = 1; prescale = 0;
    arm(0, 3, 0);
    wait_term(0, "t5_wait1");
    arm(0, 4, 0);
    chk("t5_arm_term_zero", zero[0], 1'b0);
    chk("t5_arm_term_cnt", counter_flat[W-1:0], 3);
    // Ack in the same cycle as a terminal leaves irq set.
    wait_term(0, "t5_wait2");
    irq_ack[0] = 1; step(); irq_ack[0] = 0;
    chk("t5_ack_term", irq[0], 1'b1);
    // Stop, hold, then re-arm restarts from N-1.
    stop[0] = 1; step(); stop[0] = 0;
    chk("t5_stopped", running[0], 1'b0);
    repeat (2) step();
    arm(0, 6, 0);
    chk("t5_rearm_cnt", counter_flat[W-1:0], 5);
    chk("t5_rearm_run", running[0], 1'b1);

    // N=0 behaves as N=1: terminal on every tick.
    arm(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_n0_zero", zero[0], 1'b1);
    end
    // cfg_ch=3 addresses no channel.
    arm(3, 7, 1);
    chk("t6_badch_zero", zero[0], 1'b1);
    chk("t6_badch_run", running, 3'b001);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      clken     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) prescale = PW'($urandom_range(0, 3));
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_ch    = CHW'($urandom_range(0, 3));
      cfg_load  = W'($urandom_range(0, 7));
      cfg_mode  = $urandom_range(0, 1) == 1;
      cfg_start = $urandom_range(0, 2) != 0;
      for (int c = 0; c < CH; c++) begin
        stop[c]    = ($urandom_range(0, 15) == 0);
        irq_ack[c] = ($urandom_range(0, 7) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
